// File: rtl/line_timing_tracker.sv
`default_nettype none
// ============================================================================
// Module   : line_timing_tracker
// Purpose  : Measures video line timing from vsync/de, locks onto stable frames
//            and publishes line-buffer delay-line latencies.
// Revision : 1.0
// ============================================================================
module line_timing_tracker #(
  parameter int LSIZE       = 16,
  parameter int DELAY_LINE  = 2,
  parameter int RAM_DELAY   = 3,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             de,
  output logic [LSIZE-1:0] active_width,
  output logic [LSIZE-1:0] line_total,
  output logic [LSIZE-1:0] line_lat,
  output logic [LSIZE-1:0] frame_lat,
  output logic [LSIZE-1:0] line_count,
  output logic             locked,
  output logic             timing_err
);

  localparam int               c_wide_w    = LSIZE + 4;
  localparam logic [LSIZE-1:0] c_ones      = '1;
  localparam logic [LSIZE-1:0] c_one       = LSIZE'(1);
  localparam logic [LSIZE-1:0] c_two       = LSIZE'(2);
  localparam logic [LSIZE-1:0] c_ram_delay = LSIZE'(RAM_DELAY);
  localparam logic [c_wide_w-1:0] c_dl_wide   = c_wide_w'(DELAY_LINE);
  localparam logic [c_wide_w-1:0] c_ones_wide = {4'b0000, c_ones};
  localparam logic [3:0]       c_lock      = 4'(LOCK_FRAMES);

  localparam logic [1:0] c_st_search = 2'd0;
  localparam logic [1:0] c_st_verify = 2'd1;
  localparam logic [1:0] c_st_locked = 2'd2;

  logic             r_vs, r_de, r_armed, r_in_line, r_pact, r_have_per, r_bad;
  logic [LSIZE-1:0] r_wcnt, r_pcnt, r_lines, r_fwidth, r_fper;
  logic [LSIZE-1:0] r_cand_w, r_cand_p, r_cand_n;
  logic [LSIZE-1:0] r_active_width, r_line_total, r_line_lat, r_frame_lat, r_line_count;
  logic             r_locked, r_timing_err;
  logic [1:0]       r_state, w_state_n;
  logic [3:0]       r_match_cnt, w_match_cnt_n, w_match_inc;

  logic             w_vs_rise, w_vs_fall, w_de_rise, w_de_fall, w_per_done, w_first_line;
  logic             w_wcnt_sat, w_pcnt_sat, w_bad_n, w_eval, w_valid, w_match;
  logic             w_load_cand, w_publish, w_drop;
  logic [LSIZE-1:0] w_lines_n, w_fwidth_n, w_fper_n, w_line_lat, w_frame_lat;
  logic [c_wide_w-1:0] w_prod_wide;

  assign w_vs_rise  = vsync & ~r_vs;
  assign w_vs_fall  = ~vsync & r_vs;
  // de is ignored under vsync, except a line ending exactly as vsync rises.
  assign w_de_rise  = de & ~r_de & ~vsync & ~r_vs;
  assign w_de_fall  = ~de & r_de & r_in_line & (~vsync | w_vs_rise);
  assign w_per_done = w_de_rise & r_pact;

  assign w_first_line = (r_lines == '0);
  assign w_wcnt_sat   = (r_wcnt == c_ones);
  assign w_pcnt_sat   = (r_pcnt == c_ones);

  // Frame statistics including any event in this cycle, so a coincident
  // de fall is counted before the frame is evaluated.
  assign w_lines_n  = (w_de_fall && r_lines != c_ones) ? r_lines + c_one : r_lines;
  assign w_fwidth_n = (w_de_fall & w_first_line) ? r_wcnt : r_fwidth;
  assign w_fper_n   = (w_per_done & ~r_have_per) ? r_pcnt : r_fper;
  assign w_bad_n    = r_bad | w_wcnt_sat | w_pcnt_sat | (w_lines_n == c_ones)
                    | (w_de_fall & ~w_first_line & (r_wcnt != r_fwidth))
                    | (w_per_done & r_have_per & (r_pcnt != r_fper));

  assign w_prod_wide = c_wide_w'(w_fper_n) * c_dl_wide;
  assign w_line_lat  = w_fper_n - c_ram_delay;
  assign w_frame_lat = w_prod_wide[LSIZE-1:0] - c_ram_delay;

  assign w_eval  = w_vs_rise & r_armed;
  assign w_valid = ~w_bad_n & (w_lines_n >= c_two) & (w_fper_n > c_ram_delay)
                 & (w_fper_n > w_fwidth_n) & (w_prod_wide <= c_ones_wide);
  assign w_match = (w_fwidth_n == r_cand_w) & (w_fper_n == r_cand_p) & (w_lines_n == r_cand_n);
  assign w_match_inc = r_match_cnt + 4'd1;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_vs       <= 1'b0;
      r_de       <= 1'b0;
      r_armed    <= 1'b0;
      r_in_line  <= 1'b0;
      r_pact     <= 1'b0;
      r_have_per <= 1'b0;
      r_bad      <= 1'b0;
      r_wcnt     <= '0;
      r_pcnt     <= '0;
      r_lines    <= '0;
      r_fwidth   <= '0;
      r_fper     <= '0;
    end else begin
      r_vs <= vsync;
      r_de <= de;
      if (w_vs_fall) begin
        r_armed    <= 1'b1;
        r_in_line  <= 1'b0;
        r_pact     <= 1'b0;
        r_have_per <= 1'b0;
        r_bad      <= 1'b0;
        r_wcnt     <= '0;
        r_pcnt     <= '0;
        r_lines    <= '0;
        r_fwidth   <= '0;
        r_fper     <= '0;
      end else begin
        if (w_de_rise) begin
          r_in_line <= 1'b1;
          r_wcnt    <= c_one;
        end else if (w_de_fall) begin
          r_in_line <= 1'b0;
        end else if (r_in_line && de && !w_wcnt_sat) begin
          r_wcnt <= r_wcnt + c_one;
        end
        if (w_de_rise) begin
          r_pact <= 1'b1;
          r_pcnt <= c_one;
        end else if (r_pact && !vsync && !w_pcnt_sat) begin
          r_pcnt <= r_pcnt + c_one;
        end
        if (w_per_done) r_have_per <= 1'b1;
        r_lines  <= w_lines_n;
        r_fwidth <= w_fwidth_n;
        r_fper   <= w_fper_n;
        r_bad    <= w_bad_n;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_search;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      c_st_search: if (w_eval && w_valid) w_state_n = (c_lock == 4'd1) ? c_st_locked : c_st_verify;
      c_st_verify: begin
        if (w_eval) begin
          if (w_valid && w_match) begin
            if (w_match_inc == c_lock) w_state_n = c_st_locked;
          end else if (!w_valid) begin
            w_state_n = c_st_search;
          end
        end
      end
      c_st_locked: if (w_eval && !(w_valid && w_match)) w_state_n = c_st_search;
      default:     w_state_n = c_st_search;
    endcase
  end

  always_comb begin
    w_load_cand   = 1'b0;
    w_publish     = 1'b0;
    w_drop        = 1'b0;
    w_match_cnt_n = r_match_cnt;
    case (r_state)
      c_st_search: begin
        if (w_eval && w_valid) begin
          w_load_cand   = 1'b1;
          w_match_cnt_n = 4'd1;
          w_publish     = (c_lock == 4'd1);
        end
      end
      c_st_verify: begin
        if (w_eval) begin
          if (w_valid && w_match) begin
            w_match_cnt_n = w_match_inc;
            w_publish     = (w_match_inc == c_lock);
          end else if (w_valid) begin
            w_load_cand   = 1'b1;
            w_match_cnt_n = 4'd1;
          end else begin
            w_match_cnt_n = 4'd0;
          end
        end
      end
      c_st_locked: begin
        if (w_eval && !(w_valid && w_match)) begin
          w_drop        = 1'b1;
          w_match_cnt_n = 4'd0;
        end
      end
      default: w_match_cnt_n = 4'd0;
    endcase
  end

  // Published values come from the frame just evaluated, which equals the candidate.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_match_cnt    <= 4'd0;
      r_cand_w       <= '0;
      r_cand_p       <= '0;
      r_cand_n       <= '0;
      r_active_width <= '0;
      r_line_total   <= '0;
      r_line_lat     <= '0;
      r_frame_lat    <= '0;
      r_line_count   <= '0;
      r_locked       <= 1'b0;
      r_timing_err   <= 1'b0;
    end else begin
      r_match_cnt  <= w_match_cnt_n;
      r_timing_err <= w_drop;
      if (w_load_cand) begin
        r_cand_w <= w_fwidth_n;
        r_cand_p <= w_fper_n;
        r_cand_n <= w_lines_n;
      end
      if (w_publish) begin
        r_active_width <= w_fwidth_n;
        r_line_total   <= w_fper_n;
        r_line_count   <= w_lines_n;
        r_line_lat     <= w_line_lat;
        r_frame_lat    <= w_frame_lat;
        r_locked       <= 1'b1;
      end else if (w_drop) begin
        r_locked <= 1'b0;
      end
    end
  end

  assign active_width = r_active_width;
  assign line_total   = r_line_total;
  assign line_lat     = r_line_lat;
  assign frame_lat    = r_frame_lat;
  assign line_count   = r_line_count;
  assign locked       = r_locked;
  assign timing_err   = r_timing_err;

endmodule
`default_nettype wire

// File: tb/tb_line_timing_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_timing_tracker
// Purpose  : Frame-level stimulus against a per-frame behavioural lock model,
//            applied to a 16-bit and a 6-bit instance at once.
// Revision : 1.0
// ============================================================================
module tb_line_timing_tracker;

  localparam int c_lock_frames = 2;
  localparam int c_delay_line  = 2;
  localparam int c_ram_delay   = 3;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b0;
  logic de    = 1'b0;

  logic [15:0] aw0, lt0, ll0, fl0, lc0;
  logic        lk0, te0;
  logic [5:0]  aw1, lt1, ll1, fl1, lc1;
  logic        lk1, te1;

  always #5 clock = ~clock;

  line_timing_tracker #(.LSIZE(16), .DELAY_LINE(c_delay_line), .RAM_DELAY(c_ram_delay),
                        .LOCK_FRAMES(c_lock_frames)) u_dut16 (
    .clock(clock), .rst_n(rst_n), .vsync(vsync), .de(de),
    .active_width(aw0), .line_total(lt0), .line_lat(ll0), .frame_lat(fl0),
    .line_count(lc0), .locked(lk0), .timing_err(te0)
  );

  line_timing_tracker #(.LSIZE(6), .DELAY_LINE(c_delay_line), .RAM_DELAY(c_ram_delay),
                        .LOCK_FRAMES(c_lock_frames)) u_dut6 (
    .clock(clock), .rst_n(rst_n), .vsync(vsync), .de(de),
    .active_width(aw1), .line_total(lt1), .line_lat(ll1), .frame_lat(fl1),
    .line_count(lc1), .locked(lk1), .timing_err(te1)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference state per instance (index 0: LSIZE=16, index 1: LSIZE=6)
  int m_armed;
  int m_locked[2], m_streak[2], m_err[2];
  int m_cw[2], m_cp[2], m_cn[2];
  int m_pw[2], m_pp[2], m_pn[2], m_pll[2], m_pfl[2];

  int q_w[$];
  int q_l[$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ones_of(input int k);
    return (k == 0) ? 32'hFFFF : 63;
  endfunction

  task automatic step(input logic v, input logic d);
    vsync = v;
    de    = d;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_armed = 0;
    for (int k = 0; k < 2; k++) begin
      m_locked[k] = 0; m_streak[k] = 0; m_err[k] = 0;
      m_cw[k] = 0; m_cp[k] = 0; m_cn[k] = 0;
      m_pw[k] = 0; m_pp[k] = 0; m_pn[k] = 0; m_pll[k] = 0; m_pfl[k] = 0;
    end
  endtask

  task automatic check_dut(input string tag);
    check_value({tag, ".lk16"}, 32'(lk0), 32'(m_locked[0]));
    check_value({tag, ".te16"}, 32'(te0), 32'(m_err[0]));
    check_value({tag, ".aw16"}, 32'(aw0), 32'(m_pw[0]));
    check_value({tag, ".lt16"}, 32'(lt0), 32'(m_pp[0]));
    check_value({tag, ".lc16"}, 32'(lc0), 32'(m_pn[0]));
    check_value({tag, ".ll16"}, 32'(ll0), 32'(m_pll[0]));
    check_value({tag, ".fl16"}, 32'(fl0), 32'(m_pfl[0]));
    check_value({tag, ".lk6"},  32'(lk1), 32'(m_locked[1]));
    check_value({tag, ".te6"},  32'(te1), 32'(m_err[1]));
    check_value({tag, ".aw6"},  32'(aw1), 32'(m_pw[1]));
    check_value({tag, ".lt6"},  32'(lt1), 32'(m_pp[1]));
    check_value({tag, ".lc6"},  32'(lc1), 32'(m_pn[1]));
    check_value({tag, ".ll6"},  32'(ll1), 32'(m_pll[1]));
    check_value({tag, ".fl6"},  32'(fl1), 32'(m_pfl[1]));
  endtask

  // Judges the frame in q_w/q_l as a whole and advances the lock model.
  task automatic model_eval();
    int n, fw, fp, ones;
    bit b, ok, same;
    n  = q_w.size();
    fw = q_w[0];
    fp = (n > 1) ? q_w[0] + q_l[0] : 0;
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0;
      ones = ones_of(k);
      b = (n >= ones);
      for (int i = 0; i < n; i++) begin
        if (q_w[i] != fw) b = 1;
        if (i < n - 1 && q_w[i] + q_l[i] != fp) b = 1;
        if (q_w[i] >= ones || q_w[i] + q_l[i] >= ones) b = 1;
      end
      ok = !b && n >= 2 && fp > c_ram_delay && fp > fw && c_delay_line * fp <= ones;
      if (m_armed == 0) continue;
      same = (fw == m_cw[k] && fp == m_cp[k] && n == m_cn[k]);
      if (m_locked[k] != 0) begin
        if (!(ok && same)) begin
          m_locked[k] = 0; m_err[k] = 1; m_streak[k] = 0;
        end
      end else if (ok) begin
        if (m_streak[k] > 0 && same) m_streak[k]++;
        else begin
          m_cw[k] = fw; m_cp[k] = fp; m_cn[k] = n; m_streak[k] = 1;
        end
        if (m_streak[k] >= c_lock_frames) begin
          m_locked[k] = 1;
          m_pw[k] = fw; m_pp[k] = fp; m_pn[k] = n;
          m_pll[k] = (fp - c_ram_delay) & ones;
          m_pfl[k] = (c_delay_line * fp - c_ram_delay) & ones;
        end
      end else begin
        m_streak[k] = 0;
      end
    end
  endtask

  task automatic uni(input int n, input int w, input int l);
    q_w.delete();
    q_l.delete();
    for (int i = 0; i < n; i++) begin
      q_w.push_back(w);
      q_l.push_back(l);
    end
  endtask

  // One frame: vsync fall, porch, lines, then 30 cycles of vsync.
  task automatic run_frame(input bit vs_pulse, input int rst_line);
    m_armed = 1;
    repeat (4) step(1'b0, 1'b0);
    for (int i = 0; i < q_w.size(); i++) begin
      if (i == rst_line) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_dut("midrst");
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
      end
      repeat (q_w[i]) step(1'b0, 1'b1);
      repeat (q_l[i]) step(1'b0, 1'b0);
    end
    step(1'b1, 1'b0);
    model_eval();
    check_dut("fend");
    for (int c = 1; c < 30; c++) begin
      step(1'b1, vs_pulse && c >= 5 && c < 12);
      if (c == 1) begin
        check_value("errpulse16", 32'(te0), 32'd0);
        check_value("errpulse6",  32'(te1), 32'd0);
      end
    end
  endtask

  initial begin
    int sv_w[$];
    int sv_l[$];
    int n, w, l;

    model_reset();
    repeat (3) step(1'b0, 1'b0);
    check_dut("reset");
    rst_n = 1'b1;
    repeat (30) step(1'b1, 1'b0);

    // Initial lock
    uni(4, 16, 8);
    run_frame(1'b0, -1);
    check_value("plan_f1_unlocked", 32'(lk0), 32'd0);
    run_frame(1'b0, -1);
    check_value("plan_lock", 32'(lk0), 32'd1);
    check_value("plan_lt", 32'(lt0), 32'd24);
    check_value("plan_ll", 32'(ll0), 32'd21);
    check_value("plan_fl", 32'(fl0), 32'd45);
    check_value("plan_lc", 32'(lc0), 32'd4);
    run_frame(1'b0, -1);

    // Loss of lock: one line short
    uni(4, 16, 8);
    q_w[2] = 15;
    run_frame(1'b0, -1);
    check_value("plan_loss_lk", 32'(lk0), 32'd0);
    check_value("plan_hold_fl", 32'(fl0), 32'd45);
    uni(4, 16, 8);
    run_frame(1'b0, -1);
    run_frame(1'b0, -1);
    check_value("plan_relock", 32'(lk0), 32'd1);

    // Candidate change while verifying
    uni(1, 16, 8);
    run_frame(1'b0, -1);
    uni(4, 16, 8);
    run_frame(1'b0, -1);
    uni(4, 20, 8);
    run_frame(1'b0, -1);
    check_value("plan_restart", 32'(lk0), 32'd0);
    run_frame(1'b0, -1);
    check_value("plan_lt28", 32'(lt0), 32'd28);
    check_value("plan_fl53", 32'(fl0), 32'd53);

    // Invalid single-line frames, then de pulses under vsync
    uni(1, 16, 8);
    run_frame(1'b0, -1);
    run_frame(1'b0, -1);
    uni(4, 20, 8);
    run_frame(1'b1, -1);
    run_frame(1'b1, -1);
    check_value("plan_vspulse_lock", 32'(lk0), 32'd1);

    // Last de fall coincident with vsync rise
    q_l[3] = 0;
    run_frame(1'b0, -1);

    // Reset during line 2 of a locked stream
    uni(4, 20, 8);
    run_frame(1'b0, 1);
    run_frame(1'b0, -1);
    run_frame(1'b0, -1);
    check_value("plan_rst_relock", 32'(lk0), 32'd1);

    // Period overflows the 6-bit instance
    uni(4, 16, 54);
    repeat (3) run_frame(1'b0, -1);
    check_value("plan_sat_unlocked", 32'(lk1), 32'd0);

    // Randomized frames, repeating often so locks occur
    sv_w = q_w;
    sv_l = q_l;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) < 6) begin
        q_w = sv_w;
        q_l = sv_l;
      end else begin
        n = $urandom_range(1, 5);
        w = $urandom_range(2, 36);
        l = $urandom_range(1, 30);
        uni(n, w, l);
        if ($urandom_range(0, 3) == 0) q_l[n-1] = 0;
        sv_w = q_w;
        sv_l = q_l;
        if ($urandom_range(0, 3) == 0) begin
          int idx;
          idx = $urandom_range(0, n - 1);
          q_w[idx] = q_w[idx] + 1;
        end
      end
      run_frame($urandom_range(0, 3) == 0, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
